// File: rtl/hex_display_pkg.sv
// Shared definitions for the hex display controller: command codes, blank
// segment pattern, FSM states and the write-pointer arithmetic helpers.
package hex_display_pkg;

  localparam int MAX_DIGITS = 8;

  localparam logic [4:0] CMD_DISP   = 5'b00000;
  localparam logic [4:0] CMD_SETPTR = 5'b11110;
  localparam logic [4:0] CMD_CLR    = 5'b11111;

  // Active-low segments, so all-ones turns every segment off.
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic {
    IDLE,
    SCAN
  } state_e;

  function automatic logic [2:0] wrap_nibble(input logic [3:0] v, input int num_digits);
    return 3'(32'(v) % num_digits);
  endfunction

  function automatic logic [2:0] next_ptr(input logic [2:0] ptr, input int num_digits);
    return (ptr == 3'(num_digits - 1)) ? 3'd0 : ptr + 3'd1;
  endfunction

endpackage

// File: rtl/hex_display_ctrl_if.sv
// Processor-side write port of the hex display controller: command strobe,
// nibble operand, and the status the processor polls back.
interface hex_display_ctrl_if;
  logic       wr_valid;
  logic [4:0] command;
  logic [3:0] bus;
  logic       ready;
  logic       overflow;
  logic [2:0] ptr;

  modport master (
    output wr_valid, command, bus,
    input  ready, overflow, ptr
  );

  modport slave (
    input  wr_valid, command, bus,
    output ready, overflow, ptr
  );
endinterface

// File: rtl/hex_seg_lut.sv
// Combinational hex nibble to seven-segment decoder, active-low, gfedcba.
module hex_seg_lut
  import hex_display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    seg = SEG_BLANK;
    case (nibble)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'ha: seg = 7'b0001000;
      4'hb: seg = 7'b0000011;
      4'hc: seg = 7'b1000110;
      4'hd: seg = 7'b0100001;
      4'he: seg = 7'b0000110;
      4'hf: seg = 7'b0001110;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/hex_display_ctrl.sv
// Debug hex display controller: buffers processor nibble writes and sweeps one
// digit per cycle through a single shared decoder into per-digit segment registers.
module hex_display_ctrl
  import hex_display_pkg::*;
#(
  parameter int NUM_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  hex_display_ctrl_if.slave       cpu,
  output logic [7*NUM_DIGITS-1:0] hex
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [2:0]       ptr_q;
  logic             overflow_q;
  logic [3:0]       nib_q [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] blank_q;
  logic [6:0]       seg_q [NUM_DIGITS];

  logic       accept;
  logic       do_disp;
  logic       do_setptr;
  logic       do_clr;
  logic       last_idx;
  logic [3:0] lut_in;
  logic       cur_blank;
  logic [6:0] lut_out;
  logic [6:0] seg_next;

  always_comb begin
    accept    = cpu.wr_valid && (state_q == IDLE);
    do_disp   = accept && (cpu.command == CMD_DISP);
    do_setptr = accept && (cpu.command == CMD_SETPTR);
    do_clr    = accept && (cpu.command == CMD_CLR);
    last_idx  = (idx_q == IDX_W'(NUM_DIGITS - 1));
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (do_disp || do_clr) begin
          state_d = SCAN;
          idx_d   = '0;
        end
      end
      SCAN: begin
        if (last_idx) begin
          state_d = IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Select the digit under the sweep cursor into the one shared decoder.
  always_comb begin
    lut_in    = '0;
    cur_blank = 1'b1;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (idx_q == IDX_W'(d)) begin
        lut_in    = nib_q[d];
        cur_blank = blank_q[d];
      end
    end
  end

  hex_seg_lut u_lut (
    .nibble (lut_in),
    .seg    (lut_out)
  );

  assign seg_next = cur_blank ? SEG_BLANK : lut_out;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // NOTE: the buffers are reset explicitly because their reset contents (blank digits) are visible on the pins.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q      <= '0;
      overflow_q <= 1'b0;
      blank_q    <= '1;
      for (int d = 0; d < NUM_DIGITS; d++) nib_q[d] <= '0;
    end else begin
      if (cpu.wr_valid && (state_q != IDLE)) overflow_q <= 1'b1;

      if (do_disp) begin
        for (int d = 0; d < NUM_DIGITS; d++) begin
          if (ptr_q == 3'(d)) begin
            nib_q[d]   <= cpu.bus;
            blank_q[d] <= 1'b0;
          end
        end
        ptr_q <= next_ptr(ptr_q, NUM_DIGITS);
      end else if (do_setptr) begin
        ptr_q <= wrap_nibble(cpu.bus, NUM_DIGITS);
      end else if (do_clr) begin
        ptr_q   <= '0;
        blank_q <= '1;
        for (int d = 0; d < NUM_DIGITS; d++) nib_q[d] <= '0;
      end
    end
  end

  // Only the digit under the cursor is written, so digits ahead of the sweep hold steady.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int d = 0; d < NUM_DIGITS; d++) seg_q[d] <= SEG_BLANK;
    end else if (state_q == SCAN) begin
      for (int d = 0; d < NUM_DIGITS; d++) begin
        if (idx_q == IDX_W'(d)) seg_q[d] <= seg_next;
      end
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_hex
    assign hex[7*g +: 7] = seg_q[g];
  end

  assign cpu.ready    = (state_q == IDLE);
  assign cpu.overflow = overflow_q;
  assign cpu.ptr      = ptr_q;

endmodule

// File: doc/hex_display_ctrl.md
# hex_display_ctrl

Sequences a shared hex-to-seven-segment lookup across a bank of display digits for the processor's debug display. Accepts nibble writes and control commands from the processor bus, holds a per-digit nibble buffer, and on every change runs a one-digit-per-cycle refresh sweep through a single decoder instance. The decoded patterns are latched into per-digit segment registers that drive the board's HEX pins.

## Interface
- NUM_DIGITS, 4: digits managed; legal range 1..8.
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_valid  in  1  single-cycle strobe qualifying command/bus.
- command  in  5  processor command code.
- bus  in  4  nibble operand.
- ready  out  1  high when idle and able to accept a write.
- overflow  out  1  sticky; set when a write is dropped.
- ptr  out  3  current write pointer; upper bits zero when NUM_DIGITS < 8.
- hex  out  7*NUM_DIGITS  segment patterns, active-low, gfedcba (bit 0 = a); digit d at hex[7*d +: 7].

## Operation
- Commands are decoded only when wr_valid && ready:
  - CMD_DISP = 5'b00000: buf[ptr] <= bus; blank[ptr] <= 0; ptr <= (ptr+1) mod NUM_DIGITS; start a sweep.
  - CMD_SETPTR = 5'b11110: ptr <= bus mod NUM_DIGITS; no sweep, ready stays high.
  - CMD_CLR = 5'b11111: all buf <= 0; all blank <= 1; ptr <= 0; start a sweep.
  - Any other code: ignored; no state change.
- wr_valid && !ready: write dropped; overflow <= 1. overflow clears only on rst.
- FSM states:
  - IDLE: ready = 1. An accepted DISP or CLR moves to SCAN with idx <= 0.
  - SCAN: drive buf[idx] into the shared decoder. Latch hex[idx] <= blank[idx] ? 7'b1111111 : lut(buf[idx]). If idx == NUM_DIGITS-1, go to IDLE; otherwise idx++.
- Lookup, active-low: 0 → 1000000, 1 → 1111001, 2 → 0100100, 3 → 0110000, 4 → 0011001, 5 → 0010010, 6 → 0000010, 7 → 1111000, 8 → 0000000, 9 → 0010000, A → 0001000, b → 0000011, C → 1000110, d → 0100001, E → 0000110, F → 0001110.
- Pointer wrap: a DISP at ptr = NUM_DIGITS-1 wraps ptr to 0.

## Timing
- Reset values: state IDLE, ready 1, overflow 0, ptr 0, idx 0, all buf 0, all blank 1, every hex digit 7'b1111111.
- Write accepted at edge t: buf, blank and ptr update at t. SCAN occupies cycles t+1 .. t+NUM_DIGITS. hex[d] updates at edge t+1+d. ready is low during SCAN and high again in cycle t+NUM_DIGITS+1.
- Sweep latency from write to last digit updated: NUM_DIGITS cycles. Minimum spacing between accepted DISP writes: NUM_DIGITS+1 cycles.
- SETPTR is accepted and takes effect in 1 cycle. It may be issued back-to-back.
- rst has priority over wr_valid in the same cycle.
- rst during SCAN aborts the sweep. All outputs take their reset values on the next edge.
- hex digits not yet reached in a sweep hold their previous values (no glitching to intermediate values).

## Structure
- Shared package hex_display_pkg:
  - CMD_DISP, CMD_SETPTR, CMD_CLR.
  - SEG_BLANK = 7'b1111111.
  - State enum {IDLE, SCAN}.
- Sub-module hex_seg_lut: purely combinational 4-bit → 7-bit lookup, instantiated exactly once and shared by the sweep.
- Top level holds the FSM, buffers, pointer and segment registers.

## Test plan
- Reset: assert rst 2 cycles → every hex = 7'h7F, ready = 1, ptr = 0, overflow = 0.
- DISP writes of bus = 1, 2, 3, 4, each issued after ready returns → hex0..3 = 1111001, 0100100, 0110000, 0011001. ptr wraps to 0. Each sweep holds ready low exactly 4 cycles.
- Second DISP one cycle after an accepted write → write dropped, overflow = 1, buffer unchanged. overflow stays 1 after later accepted writes until rst.
- SETPTR bus = 2, then DISP bus = F → only hex2 = 0001110, ptr = 3. Unknown command 5'b00101 → no change, ready stays 1.
- CLR after digits are loaded → all hex = 7'h7F after 4 sweep cycles, ptr = 0.
- rst asserted in the 2nd SCAN cycle, together with wr_valid → sweep aborted, all outputs at reset values next cycle, write ignored.
